// File: rtl/buff_uart_pkg.sv
// Shared types for the UART command sequencer: command opcode encoding
// and the sequencer state enum, plus command-byte field positions.
package buff_uart_pkg;

    // Opcode in command byte bits [7:6]; the value 3 is not a member
    // and is rejected as an invalid opcode.
    typedef enum logic [1:0] {
        READ         = 2'd0,
        WRITE        = 2'd1,
        READ_N_WRITE = 2'd2
    } ADDRESSED_DIRECTION;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_DATA,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_SEND
    } seq_state_t;

    localparam int          CMD_OP_MSB = 7;
    localparam int          CMD_OP_LSB = 6;
    localparam logic [1:0]  OP_INVALID = 2'd3;

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Signal bundle between the sequencer, the UART rx/tx side and the
// addressable slaves. master = sequencer, slave = UART + slave fabric.
interface uart_cmd_sequencer_if #(
    parameter int address_width = 4,
    parameter int data_width    = 8
);
    logic [data_width-1:0]    rx_data;
    logic                     rx_valid;
    logic [data_width-1:0]    tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic [address_width-1:0] active_address;
    logic                     read_enable;
    logic                     write_enable;
    logic [data_width-1:0]    write_data;
    logic [data_width-1:0]    read_data;
    logic                     busy;
    logic                     error;

    modport master (
        input  rx_data, rx_valid, tx_ready, read_data,
        output tx_data, tx_valid, active_address,
        output read_enable, write_enable, write_data,
        output busy, error
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, read_data,
        input  tx_data, tx_valid, active_address,
        input  read_enable, write_enable, write_data,
        input  busy, error
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Decodes command bytes from a UART receiver into read/write strobes on a
// shared slave bus and returns read results toward the UART transmitter.
// Ports: clk, rst (async, active-high), bus (uart_cmd_sequencer_if.master):
//   rx_data/rx_valid in, tx_data/tx_valid out with tx_ready in,
//   active_address/read_enable/write_enable/write_data out, read_data in,
//   busy and error status out.
module uart_cmd_sequencer
    import buff_uart_pkg::*;
#(
    parameter int address_width = 4,
    parameter int data_width    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_sequencer_if.master bus
);

    seq_state_t               state_q, state_d;
    ADDRESSED_DIRECTION       op_q;
    logic [address_width-1:0] addr_q;
    logic [data_width-1:0]    wdata_q;
    logic [data_width-1:0]    tx_q;
    logic                     err_q, err_d;

    logic [1:0] cmd_op;
    logic       op_ok;
    logic       busy_w;

    assign cmd_op = bus.rx_data[CMD_OP_MSB:CMD_OP_LSB];
    assign op_ok  = (cmd_op != OP_INVALID);

    // Outputs are pure decodes of the state register.
    assign busy_w = (state_q != S_IDLE) && (state_q != S_GET_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        // Bytes arriving mid-operation are dropped and flagged.
        err_d   = bus.rx_valid && (busy_w || (state_q == S_IDLE && !op_ok));
        unique case (state_q)
            S_IDLE: begin
                if (bus.rx_valid && op_ok) begin
                    if (cmd_op == READ) state_d = S_READ;
                    else                state_d = S_GET_DATA;
                end
            end
            S_GET_DATA: begin
                if (bus.rx_valid) begin
                    if (op_q == WRITE) state_d = S_WRITE;
                    else               state_d = S_READ;
                end
            end
            S_READ:    state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (op_q == READ) state_d = S_SEND;
                else              state_d = S_WRITE;
            end
            S_WRITE: begin
                if (op_q == WRITE) state_d = S_IDLE;
                else               state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.tx_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= READ;
            addr_q  <= '0;
            wdata_q <= '0;
            tx_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_d;
            if (state_q == S_IDLE && bus.rx_valid) begin
                addr_q <= bus.rx_data[address_width-1:0];
                if (op_ok) op_q <= ADDRESSED_DIRECTION'(cmd_op);
            end
            if (state_q == S_GET_DATA && bus.rx_valid)
                wdata_q <= bus.rx_data;
            // Slave read bus is valid the cycle after read_enable.
            if (state_q == S_CAPTURE)
                tx_q <= bus.read_data;
        end
    end

    assign bus.active_address = addr_q;
    assign bus.write_data     = wdata_q;
    assign bus.tx_data        = tx_q;
    assign bus.read_enable    = (state_q == S_READ);
    assign bus.write_enable   = (state_q == S_WRITE);
    assign bus.tx_valid       = (state_q == S_SEND);
    assign bus.busy           = busy_w;
    assign bus.error          = err_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer.
// Expected tx bytes and write transactions are queued at stimulus time.
module tb_uart_cmd_sequencer;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tx_q[$];
    wr_t        wr_q[$];

    uart_cmd_sequencer_if ifc ();

    uart_cmd_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        tick();
        ifc.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [30:0] obs;
        rst = 1'b1;
        tick();
        tick();
        obs = {ifc.tx_data, ifc.tx_valid, ifc.active_address,
               ifc.read_enable, ifc.write_enable, ifc.write_data,
               ifc.busy, ifc.error};
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", obs);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        logic [7:0] e;
        tx_q.push_back(8'hA7);
        send(8'h05);
        ifc.read_data = 8'h5A;
        n_checks++;
        if ({ifc.read_enable, ifc.write_enable, ifc.active_address}
            !== {1'b1, 1'b0, 4'd5}) begin
            n_fail++;
            $display("FAIL read_strobe: re=%b we=%b addr=%h want 1 0 5",
                     ifc.read_enable, ifc.write_enable, ifc.active_address);
        end
        tick();
        ifc.read_data = 8'hA7;
        n_checks++;
        if ({ifc.read_enable, ifc.tx_valid, ifc.busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL read_capture: re=%b txv=%b busy=%b want 0 0 1",
                     ifc.read_enable, ifc.tx_valid, ifc.busy);
        end
        tick();
        ifc.read_data = 8'h00;
        n_checks++;
        if (ifc.tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL read_latency: tx_valid=%b want 1", ifc.tx_valid);
        end
        e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
        n_checks++;
        if (ifc.tx_data !== e) begin
            n_fail++;
            $display("FAIL read_data: got %h want %h", ifc.tx_data, e);
        end
        tick();
        n_checks++;
        if ({ifc.tx_valid, ifc.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL read_done: txv=%b busy=%b want 0 0",
                     ifc.tx_valid, ifc.busy);
        end
    endtask

    task automatic test_write();
        wr_t w;
        logic saw_tx;
        saw_tx = 1'b0;
        wr_q.push_back('{a: 4'd3, d: 8'h3C});
        send(8'h43);
        n_checks++;
        if ({ifc.busy, ifc.write_enable, ifc.active_address}
            !== {1'b0, 1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL get_data_wait: busy=%b we=%b addr=%h want 0 0 3",
                     ifc.busy, ifc.write_enable, ifc.active_address);
        end
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if ({ifc.write_enable, ifc.read_enable} !== 2'b00) begin
            n_fail++;
            $display("FAIL get_data_idle: we=%b re=%b want 0 0",
                     ifc.write_enable, ifc.read_enable);
        end
        send(8'h3C);
        saw_tx |= ifc.tx_valid;
        w = (wr_q.size() != 0) ? wr_q.pop_front() : '{a: 'x, d: 'x};
        n_checks++;
        if ({ifc.write_enable, ifc.read_enable, ifc.active_address,
             ifc.write_data} !== {1'b1, 1'b0, w.a, w.d}) begin
            n_fail++;
            $display("FAIL write_strobe: we=%b re=%b addr=%h wd=%h want 1 0 %h %h",
                     ifc.write_enable, ifc.read_enable, ifc.active_address,
                     ifc.write_data, w.a, w.d);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_tx |= ifc.tx_valid;
        end
        n_checks++;
        if ({saw_tx, ifc.write_enable, ifc.busy, ifc.write_data}
            !== {3'b000, 8'h3C}) begin
            n_fail++;
            $display("FAIL write_done: txv_seen=%b we=%b busy=%b wd=%h want 0 0 0 3c",
                     saw_tx, ifc.write_enable, ifc.busy, ifc.write_data);
        end
    endtask

    task automatic test_rnw();
        wr_t w;
        logic [7:0] e;
        tx_q.push_back(8'h99);
        wr_q.push_back('{a: 4'hA, d: 8'h11});
        send(8'h8A);
        send(8'h11);
        ifc.read_data = 8'h66;
        n_checks++;
        if ({ifc.read_enable, ifc.write_enable, ifc.active_address}
            !== {1'b1, 1'b0, 4'hA}) begin
            n_fail++;
            $display("FAIL rnw_read: re=%b we=%b addr=%h want 1 0 a",
                     ifc.read_enable, ifc.write_enable, ifc.active_address);
        end
        tick();
        ifc.read_data = 8'h99;
        n_checks++;
        if ({ifc.read_enable, ifc.write_enable, ifc.tx_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rnw_capture: re=%b we=%b txv=%b want 0 0 0",
                     ifc.read_enable, ifc.write_enable, ifc.tx_valid);
        end
        tick();
        ifc.read_data = 8'h00;
        w = (wr_q.size() != 0) ? wr_q.pop_front() : '{a: 'x, d: 'x};
        n_checks++;
        if ({ifc.write_enable, ifc.read_enable, ifc.active_address,
             ifc.write_data} !== {1'b1, 1'b0, w.a, w.d}) begin
            n_fail++;
            $display("FAIL rnw_write: we=%b re=%b addr=%h wd=%h want 1 0 %h %h",
                     ifc.write_enable, ifc.read_enable, ifc.active_address,
                     ifc.write_data, w.a, w.d);
        end
        tick();
        e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
        n_checks++;
        if ({ifc.tx_valid, ifc.tx_data} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL rnw_send: txv=%b txd=%h want 1 %h",
                     ifc.tx_valid, ifc.tx_data, e);
        end
        tick();
        n_checks++;
        if ({ifc.tx_valid, ifc.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rnw_done: txv=%b busy=%b want 0 0",
                     ifc.tx_valid, ifc.busy);
        end
    endtask

    task automatic test_invalid();
        send(8'hC0);
        n_checks++;
        if ({ifc.error, ifc.read_enable, ifc.write_enable, ifc.busy}
            !== 4'b1000) begin
            n_fail++;
            $display("FAIL invalid_err: err=%b re=%b we=%b busy=%b want 1 0 0 0",
                     ifc.error, ifc.read_enable, ifc.write_enable, ifc.busy);
        end
        tick();
        n_checks++;
        if ({ifc.error, ifc.read_enable, ifc.write_enable, ifc.busy}
            !== 4'b0000) begin
            n_fail++;
            $display("FAIL invalid_after: err=%b re=%b we=%b busy=%b want 0 0 0 0",
                     ifc.error, ifc.read_enable, ifc.write_enable, ifc.busy);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        ifc.tx_ready = 1'b0;
        tx_q.push_back(8'h5E);
        send(8'h07);
        tick();
        ifc.read_data = 8'h5E;
        tick();
        ifc.read_data = 8'h00;
        e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({ifc.tx_valid, ifc.tx_data} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL hold_%0d: txv=%b txd=%h want 1 %h",
                         i, ifc.tx_valid, ifc.tx_data, e);
            end
            if (i == 4) send(8'hFF);
            else        tick();
            if (i == 4) begin
                n_checks++;
                if ({ifc.error, ifc.tx_valid, ifc.tx_data} !== {2'b11, e}) begin
                    n_fail++;
                    $display("FAIL send_drop: err=%b txv=%b txd=%h want 1 1 %h",
                             ifc.error, ifc.tx_valid, ifc.tx_data, e);
                end
            end
        end
        ifc.tx_ready = 1'b1;
        tick();
        n_checks++;
        if ({ifc.tx_valid, ifc.busy, ifc.error, ifc.tx_data}
            !== {3'b000, e}) begin
            n_fail++;
            $display("FAIL bp_release: txv=%b busy=%b err=%b txd=%h want 0 0 0 %h",
                     ifc.tx_valid, ifc.busy, ifc.error, ifc.tx_data, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [30:0] obs;
        logic strobe;
        logic [7:0] e;
        send(8'h41);
        rst = 1'b1;
        #1;
        obs = {ifc.tx_data, ifc.tx_valid, ifc.active_address,
               ifc.read_enable, ifc.write_enable, ifc.write_data,
               ifc.busy, ifc.error};
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 0", obs);
        end
        tick();
        rst = 1'b0;
        strobe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            strobe |= ifc.read_enable | ifc.write_enable | ifc.busy;
        end
        n_checks++;
        if (strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_quiet: activity=%b want 0", strobe);
        end
        tx_q.push_back(8'h3D);
        send(8'h22);
        n_checks++;
        if ({ifc.read_enable, ifc.write_enable, ifc.active_address}
            !== {1'b1, 1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL fresh_cmd: re=%b we=%b addr=%h want 1 0 2",
                     ifc.read_enable, ifc.write_enable, ifc.active_address);
        end
        ifc.read_data = 8'h3D;
        tick();
        tick();
        e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
        n_checks++;
        if ({ifc.tx_valid, ifc.tx_data} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL fresh_send: txv=%b txd=%h want 1 %h",
                     ifc.tx_valid, ifc.tx_data, e);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            logic [1:0] op;
            logic [3:0] a;
            logic [7:0] d, rd, e;
            logic [1:0] pad;
            logic done;
            wr_t w;
            op  = 2'($urandom_range(0, 2));
            a   = 4'($urandom_range(0, 15));
            d   = 8'($urandom_range(0, 255));
            rd  = 8'($urandom_range(0, 255));
            pad = 2'($urandom_range(0, 3));
            if (op != 2'd1) tx_q.push_back(rd);
            if (op != 2'd0) wr_q.push_back('{a: a, d: d});
            ifc.read_data = rd;
            send({op, pad, a});
            if (op != 2'd0) send(d);
            done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                if (ifc.read_enable) begin
                    n_checks++;
                    if ({ifc.write_enable, ifc.active_address} !== {1'b0, a}) begin
                        n_fail++;
                        $display("FAIL b2b_read_%0d: we=%b addr=%h want 0 %h",
                                 k, ifc.write_enable, ifc.active_address, a);
                    end
                end
                if (ifc.write_enable) begin
                    w = (wr_q.size() != 0) ? wr_q.pop_front() : '{a: 'x, d: 'x};
                    n_checks++;
                    if ({ifc.active_address, ifc.write_data} !== {w.a, w.d}) begin
                        n_fail++;
                        $display("FAIL b2b_write_%0d: addr=%h wd=%h want %h %h",
                                 k, ifc.active_address, ifc.write_data, w.a, w.d);
                    end
                    if (op == 2'd1) done = 1'b1;
                end
                if (ifc.tx_valid && ifc.tx_ready) begin
                    e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
                    n_checks++;
                    if (ifc.tx_data !== e) begin
                        n_fail++;
                        $display("FAIL b2b_tx_%0d: got %h want %h",
                                 k, ifc.tx_data, e);
                    end
                    done = 1'b1;
                end
                tick();
            end
            if (!done) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b_timeout_%0d: op=%0d no completion", k, op);
            end
        end
        n_checks++;
        if (tx_q.size() + wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_leftover: tx=%0d wr=%0d want 0 0",
                     tx_q.size(), wr_q.size());
        end
    endtask

    initial begin
        ifc.rx_data   = 8'h00;
        ifc.rx_valid  = 1'b0;
        ifc.tx_ready  = 1'b1;
        ifc.read_data = 8'h00;
        test_reset();
        test_read();
        test_write();
        test_rnw();
        test_invalid();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_cmd_sequencer.md
UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 Parameter address_width, default 4, width of active_address and of the command address field (1..6).
REQ-002 Parameter data_width, default 8, width of rx_data, tx_data, write_data and read_data; fixed at 8 for the command format below.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  byte from UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-007 tx_data  output  8  read result toward UART transmitter.
REQ-008 tx_valid  output  1  tx_data valid; held until accepted.
REQ-009 tx_ready  input  1  transmitter accepts tx_data when tx_valid and tx_ready are both high.
REQ-010 active_address  output  address_width  target address broadcast to all addressable slaves.
REQ-011 read_enable  output  1  one-cycle read strobe to all slaves.
REQ-012 write_enable  output  1  one-cycle write strobe to all slaves.
REQ-013 write_data  output  8  data accompanying write_enable.
REQ-014 read_data  input  8  shared slave read bus, valid the cycle after read_enable.
REQ-015 busy  output  1  high in every state except IDLE and GET_DATA.
REQ-016 error  output  1  one-cycle pulse: invalid opcode or byte dropped.

Function
REQ-017 Command byte: bits[7:6] opcode using ADDRESSED_DIRECTION encoding (READ=0, WRITE=1, READ_N_WRITE=2); 3 invalid; bits[address_width-1:0] address; remaining bits ignored.
REQ-018 States: IDLE, GET_DATA, READ, CAPTURE, WRITE, SEND.
REQ-019 IDLE + rx_valid: latch address into active_address; READ -> READ; WRITE or READ_N_WRITE -> GET_DATA; opcode 3 -> error pulse next cycle, stay IDLE.
REQ-020 GET_DATA + rx_valid: latch rx_data into write_data; WRITE -> WRITE; READ_N_WRITE -> READ.
REQ-021 READ lasts exactly one cycle with read_enable=1, then CAPTURE.
REQ-022 CAPTURE: read_data registered into tx_data at end of cycle; READ -> SEND; READ_N_WRITE -> WRITE.
REQ-023 WRITE lasts exactly one cycle with write_enable=1; WRITE -> IDLE; READ_N_WRITE -> SEND.
REQ-024 SEND: tx_valid=1; tx_data stable; on tx_valid&&tx_ready -> IDLE.
REQ-025 read_enable, write_enable, tx_valid, busy decoded from the state register (Moore); never both strobes in one cycle.
REQ-026 Latency READ: command strobe at cycle N -> read_enable at N+1 -> tx_valid from N+3.
REQ-027 Latency WRITE: data strobe at cycle M -> write_enable at M+1.
REQ-028 rx_valid in READ, CAPTURE, WRITE or SEND: byte dropped, error pulse next cycle, operation continues unchanged.
REQ-029 GET_DATA waits indefinitely; no timeout.
REQ-030 active_address and write_data hold their last values in IDLE.

Reset
REQ-031 rst high: immediately state=IDLE, active_address=0, write_data=0, tx_data=0, tx_valid=0, read_enable=0, write_enable=0, busy=0, error=0.
REQ-032 Reset mid-operation abandons the command; no strobe is issued after reset deassertion without a new command byte.

Structure
REQ-033 ADDRESSED_DIRECTION typedef and the sequencer state enum SHALL live in shared package buff_uart_pkg.
REQ-034 Block is a single module with no sub-module; it drives the active_address, read_enable_in and write_enable_in signals of addressable_if instances.

Verification
REQ-035 rx 0x05 (READ addr 5), read_data=0xA7 at CAPTURE -> read_enable at N+1 with active_address=5, tx_valid at N+3 with tx_data=0xA7.
REQ-036 rx 0x43, then 0x3C -> write_enable one cycle with active_address=3, write_data=0x3C; no tx_valid.
REQ-037 rx 0x8A, then 0x11, read_data=0x99 -> read_enable, CAPTURE, then write_enable with write_data=0x11, then tx_data=0x99.
REQ-038 rx 0xC0 -> error pulse one cycle, no strobes, state IDLE.
REQ-039 READ with tx_ready low 10 cycles -> tx_valid and tx_data held; extra rx_valid during SEND -> error pulse, data unchanged.
REQ-040 rst asserted in GET_DATA -> all outputs 0 at once; after release, rx 0x22 -> behaves as fresh command.
